// File: rtl/vga_pkg.sv
// vga_pkg: shared pattern-mode encodings, bar colour table and hue period.
package vga_pkg;
    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam int HUE_PERIOD = 60;
    localparam int BAR_WIDTH  = 80;

    // {r,g,b} on/off per bar, bar 0 in the low bits:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_TABLE[idx*3 +: 3];
    endfunction
endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: video timing in / pixel out bundle.
//   master: timing source and pixel sink (drives pix_ce, syncs, col/row)
//   slave : pattern generator (drives delayed syncs and red/green/blue)
interface vga_pattern_gen_if;
    logic       pix_ce;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] col;
    logic [9:0] row;
    logic       hsync_out;
    logic       vsync_out;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    modport master (
        output pix_ce, hsync_in, vsync_in, col, row,
        input  hsync_out, vsync_out, red, green, blue
    );

    modport slave (
        input  pix_ce, hsync_in, vsync_in, col, row,
        output hsync_out, vsync_out, red, green, blue
    );
endinterface

// File: rtl/vga_box_mover.sv
// vga_box_mover: bouncing-box position, one pixel step per frame_tick.
//   clk, rst_n (async, active low), frame_tick (already qualified by pix_ce)
//   box_x, box_y: top-left corner of the box
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int ACTIVE_COL = 640,
    parameter int ACTIVE_ROW = 480,
    parameter int BOX_SIZE   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    // direction bits: 0 = moving +, 1 = moving -
    logic       dx, dy;
    logic [9:0] nx, ny;

    assign nx = dx ? box_x - 10'd1 : box_x + 10'd1;
    assign ny = dy ? box_y - 10'd1 : box_y + 10'd1;

    // Direction flips on the step that lands on an edge, so the next step
    // leaves it (576 -> 575, 0 -> 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '0;
            box_y <= '0;
            dx    <= 1'b0;
            dy    <= 1'b0;
        end else if (frame_tick) begin
            box_x <= nx;
            box_y <= ny;
            dx    <= dx ? nx != '0 : nx == 10'(ACTIVE_COL - BOX_SIZE);
            dy    <= dy ? ny != '0 : ny == 10'(ACTIVE_ROW - BOX_SIZE);
        end
    end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern generator (bars, checker, bouncing box, solid hue)
// with a 2-pix_ce pipeline from timing inputs to pixel/sync outputs.
//   clk, rst_n (async, active low), btn_next (raw pushbutton, async)
//   vid (slave): pix_ce, hsync_in, vsync_in, col, row -> hsync_out, vsync_out, red, green, blue
//   mode: pattern currently shown
// Define VGA_PATTERN_BORDER_EN to draw a white one-pixel border over every pattern.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int ACTIVE_COL = 640,
    parameter int ACTIVE_ROW = 480,
    parameter int BOX_SIZE   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    vga_pattern_gen_if.slave vid,
    output logic [1:0]       mode
);
    localparam int FW = $clog2(HUE_PERIOD);

    logic          btn_s1, btn_s2, btn_prev, btn_rise, pending;
    mode_t         mode_q;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    hue;
    logic [9:0]    col_d, row_d, box_x, box_y;
    logic          hs_d, vs_d;
    logic          frame_tick, frame_last, active, in_box;
    logic [10:0]   box_x_end, box_y_end;
    logic [2:0]    bar_idx, pat, rgb;

    assign frame_tick = vid.pix_ce && vid.col == '0 && vid.row == 10'(ACTIVE_ROW);
    assign frame_last = frame_cnt == FW'(HUE_PERIOD - 1);
    // btn_prev only advances on pix_ce, so a synchronised level lasting
    // at least one pixel period is always seen as exactly one rise.
    assign btn_rise   = btn_s2 & ~btn_prev;
    assign mode       = mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_next;
            btn_s2 <= btn_s1;
        end
    end

    // A rise on the consuming frame_tick re-arms pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev  <= 1'b0;
            pending   <= 1'b0;
            mode_q    <= MODE_BARS;
            frame_cnt <= '0;
            hue       <= '0;
        end else if (vid.pix_ce) begin
            btn_prev <= btn_s2;
            if (frame_tick) begin
                pending   <= btn_rise;
                mode_q    <= pending ? mode_t'(mode_q + 2'd1) : mode_q;
                frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
                hue       <= frame_last ? hue + 3'd1 : hue;
            end else begin
                pending <= pending | btn_rise;
            end
        end
    end

    vga_box_mover #(
        .ACTIVE_COL (ACTIVE_COL),
        .ACTIVE_ROW (ACTIVE_ROW),
        .BOX_SIZE   (BOX_SIZE)
    ) u_box (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    assign active    = col_d < 10'(ACTIVE_COL) && row_d < 10'(ACTIVE_ROW);
    assign bar_idx   = 3'(col_d / 10'(BAR_WIDTH));
    assign box_x_end = {1'b0, box_x} + 11'(BOX_SIZE);
    assign box_y_end = {1'b0, box_y} + 11'(BOX_SIZE);
    assign in_box    = col_d >= box_x && {1'b0, col_d} < box_x_end &&
                       row_d >= box_y && {1'b0, row_d} < box_y_end;

    assign pat = mode_q == MODE_BARS  ? bar_rgb(bar_idx) :
                 mode_q == MODE_CHECK ? {3{col_d[5] ^ row_d[5]}} :
                 mode_q == MODE_BOX   ? (in_box ? 3'b010 : 3'b001) : hue;

`ifdef VGA_PATTERN_BORDER_EN
    assign rgb = (col_d == '0 || col_d == 10'(ACTIVE_COL - 1) ||
                  row_d == '0 || row_d == 10'(ACTIVE_ROW - 1)) ? 3'b111 : pat;
`else
    assign rgb = pat;
`endif

    // Stage 1 holds the timing inputs; stage 2 is the registered pixel.
    // Stage 1 resets to an off-screen position so nothing stale is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_d         <= '1;
            row_d         <= '1;
            hs_d          <= 1'b1;
            vs_d          <= 1'b1;
            vid.hsync_out <= 1'b1;
            vid.vsync_out <= 1'b1;
            vid.red       <= '0;
            vid.green     <= '0;
            vid.blue      <= '0;
        end else if (vid.pix_ce) begin
            col_d         <= vid.col;
            row_d         <= vid.row;
            hs_d          <= vid.hsync_in;
            vs_d          <= vid.vsync_in;
            vid.hsync_out <= hs_d;
            vid.vsync_out <= vs_d;
            vid.red       <= {4{active & rgb[2]}};
            vid.green     <= {4{active & rgb[1]}};
            vid.blue      <= {4{active & rgb[0]}};
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized self-checking bench for vga_pattern_gen against
// a frame-count based reference model.
module tb_vga_pattern_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic [1:0] mode;

    vga_pattern_gen_if vid();

    vga_pattern_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .vid      (vid),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_frames;
    logic [1:0] m_mode;
    bit         m_pending;
    logic [9:0] p_c, p_r;
    logic       p_h, p_v;
    logic [11:0] e_rgb;
    logic       e_hs, e_vs;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // bounce position after n steps from 0 between 0 and mx
    function automatic int tri_pos(input int n, input int mx);
        int m;
        m = n % (2 * mx);
        return m <= mx ? m : 2 * mx - m;
    endfunction

    function automatic logic [11:0] model(input logic [1:0] md, input logic [9:0] c,
                                          input logic [9:0] r, input int f);
        logic [2:0] h;
        int bx, by;
        h  = 3'((f / 60) % 8);
        bx = tri_pos(f, 576);
        by = tri_pos(f, 416);
        if (c >= 640 || r >= 480) return 12'h000;
`ifdef VGA_PATTERN_BORDER_EN
        if (c == 0 || c == 639 || r == 0 || r == 479) return 12'hFFF;
`endif
        case (md)
            2'd0:    return bars[3'(c / 80)];
            2'd1:    return (c[5] ^ r[5]) ? 12'hFFF : 12'h000;
            2'd2:    return (int'(c) >= bx && int'(c) < bx + 64 &&
                             int'(r) >= by && int'(r) < by + 64) ? 12'h0F0 : 12'h00F;
            default: return {{4{h[2]}}, {4{h[1]}}, {4{h[0]}}};
        endcase
    endfunction

    task automatic model_reset;
        m_frames  = 0;
        m_mode    = 2'd0;
        m_pending = 1'b0;
        p_c = '1; p_r = '1; p_h = 1'b1; p_v = 1'b1;
    endtask

    // one pixel period: present inputs, one pix_ce edge, three idle clocks.
    // e_* hold what the outputs must show after it (the previous pixel).
    task automatic pix(input int c, input int r, input logic h = 1'b1, input logic v = 1'b1);
        vid.col = 10'(c); vid.row = 10'(r);
        vid.hsync_in = h; vid.vsync_in = v;
        vid.pix_ce = 1'b1;
        e_rgb = model(m_mode, p_c, p_r, m_frames);
        e_hs = p_h; e_vs = p_v;
        @(posedge clk); #1;
        vid.pix_ce = 1'b0;
        if (c == 0 && r == 480) begin
            m_frames++;
            if (m_pending) m_mode++;
            m_pending = 1'b0;
        end
        p_c = 10'(c); p_r = 10'(r); p_h = h; p_v = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press;
        btn_next = 1'b1;
        repeat (3) pix(100, 100);
        btn_next = 1'b0;
        repeat (3) pix(100, 100);
        m_pending = 1'b1;
    endtask

    task automatic test_reset;
        vid.hsync_in = 1'b0; vid.vsync_in = 1'b0;
        vid.col = 10'd85; vid.row = 10'd10; vid.pix_ce = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {vid.red, vid.green, vid.blue}); end
        checks++; if (vid.hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", vid.hsync_out); end
        checks++; if (vid.vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vid.vsync_out); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
        vid.pix_ce = 1'b0;
        rst_n = 1'b1;
        model_reset();
        pix(85, 10);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL first_pix_blank got %h exp 000", {vid.red, vid.green, vid.blue}); end
        pix(85, 10);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'hFF0) begin errors++; $display("FAIL first_pix_yellow got %h exp FF0", {vid.red, vid.green, vid.blue}); end
    endtask

    task automatic test_bars;
        pix(85, 10);
        pix(700, 10);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'hFF0) begin errors++; $display("FAIL bars_85_10 got %h exp FF0", {vid.red, vid.green, vid.blue}); end
        pix(5, 5);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL bars_700_10 got %h exp 000", {vid.red, vid.green, vid.blue}); end
        for (int i = 0; i < 40; i++) begin
            pix($urandom_range(0, 799), $urandom_range(0, 524));
            checks++; if ({vid.red, vid.green, vid.blue} !== e_rgb) begin errors++; $display("FAIL bars_rand c=%0d r=%0d got %h exp %h", p_c, p_r, {vid.red, vid.green, vid.blue}, e_rgb); end
        end
    endtask

    task automatic test_sync;
        for (int c = 655; c <= 665; c++) begin
            pix(c, 20, c >= 659 ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
            checks++; if (vid.hsync_out !== e_hs || vid.vsync_out !== e_vs) begin errors++; $display("FAIL sync_delay col=%0d got %b%b exp %b%b", c, vid.hsync_out, vid.vsync_out, e_hs, e_vs); end
            if (c == 659) begin
                checks++; if (vid.hsync_out !== 1'b1) begin errors++; $display("FAIL hsync_early got %b exp 1", vid.hsync_out); end
            end
            if (c == 660) begin
                checks++; if (vid.hsync_out !== 1'b0) begin errors++; $display("FAIL hsync_fall got %b exp 0", vid.hsync_out); end
            end
        end
    endtask

    task automatic test_buttons;
        for (int i = 0; i < 3; i++) begin
            press();
            checks++; if (mode !== 2'd0) begin errors++; $display("FAIL btn_midframe press=%0d got %0d exp 0", i, mode); end
        end
        pix(0, 480);
        checks++; if (mode !== m_mode || mode !== 2'd1) begin errors++; $display("FAIL btn_advance got %0d exp 1", mode); end
        pix(0, 480);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL btn_no_press got %0d exp 1", mode); end
    endtask

    task automatic test_checker;
        int pc[4] = '{0, 639, 640, 33};
        int pr[4] = '{0, 479, 0, 2};
        for (int i = 0; i < 34; i++) begin
            if (i < 4) pix(pc[i], pr[i]);
            else pix($urandom_range(0, 799), $urandom_range(0, 524));
            checks++; if ({vid.red, vid.green, vid.blue} !== e_rgb) begin errors++; $display("FAIL checker c=%0d r=%0d got %h exp %h", p_c, p_r, {vid.red, vid.green, vid.blue}, e_rgb); end
        end
    endtask

`ifdef VGA_PATTERN_BORDER_EN
    task automatic test_border;
        pix(0, 0);
        pix(639, 479);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'hFFF) begin errors++; $display("FAIL border_0_0 got %h exp FFF", {vid.red, vid.green, vid.blue}); end
        pix(640, 0);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'hFFF) begin errors++; $display("FAIL border_639_479 got %h exp FFF", {vid.red, vid.green, vid.blue}); end
        pix(5, 5);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL border_640_0 got %h exp 000", {vid.red, vid.green, vid.blue}); end
    endtask
`endif

    task automatic test_box;
        int bx, by;
        int pc[7], pr[7];
        press();
        pix(0, 480);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL box_mode got %0d exp 2", mode); end
        for (int k = 0; k < 2; k++) begin
            while (m_frames < 576 + k) pix(0, 480);
            bx = tri_pos(m_frames, 576);
            by = tri_pos(m_frames, 416);
            pc = '{bx, bx - 1, bx + 63, bx + 64, bx, bx, 575};
            pr = '{by, by, by + 63, by, by + 64, by - 1, by};
            pix(pc[0], pr[0]);
            for (int i = 1; i <= 7; i++) begin
                pix(i < 7 ? pc[i] : 5, i < 7 ? pr[i] : 5);
                checks++; if ({vid.red, vid.green, vid.blue} !== e_rgb) begin errors++; $display("FAIL box_edge frame=%0d c=%0d r=%0d got %h exp %h", m_frames, p_c, p_r, {vid.red, vid.green, vid.blue}, e_rgb); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            pix($urandom_range(500, 660), $urandom_range(200, 340));
            checks++; if ({vid.red, vid.green, vid.blue} !== e_rgb) begin errors++; $display("FAIL box_rand c=%0d r=%0d got %h exp %h", p_c, p_r, {vid.red, vid.green, vid.blue}, e_rgb); end
        end
    endtask

    task automatic test_solid;
        int marks[5] = '{599, 600, 959, 960, 1021};
        press();
        pix(0, 480);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL solid_mode got %0d exp 3", mode); end
        for (int k = 0; k < 5; k++) begin
            while (m_frames < marks[k]) pix(0, 480);
            pix($urandom_range(1, 638), $urandom_range(1, 478));
            pix(700, 100);
            checks++; if ({vid.red, vid.green, vid.blue} !== e_rgb) begin errors++; $display("FAIL solid_hue frame=%0d got %h exp %h", m_frames, {vid.red, vid.green, vid.blue}, e_rgb); end
        end
    endtask

    task automatic test_async_reset;
        pix(100, 50, 1'b0, 1'b0);
        pix(100, 50, 1'b0, 1'b0);
        checks++; if ({vid.red, vid.green, vid.blue, vid.hsync_out, vid.vsync_out} !== {e_rgb, 2'b00}) begin errors++; $display("FAIL pre_reset got %h exp %h", {vid.red, vid.green, vid.blue, vid.hsync_out, vid.vsync_out}, {e_rgb, 2'b00}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL async_rgb got %h exp 000", {vid.red, vid.green, vid.blue}); end
        checks++; if ({vid.hsync_out, vid.vsync_out} !== 2'b11) begin errors++; $display("FAIL async_sync got %b exp 11", {vid.hsync_out, vid.vsync_out}); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL async_mode got %0d exp 0", mode); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        pix(120, 200);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'h000) begin errors++; $display("FAIL restart_blank got %h exp 000", {vid.red, vid.green, vid.blue}); end
        pix(120, 200);
        checks++; if ({vid.red, vid.green, vid.blue} !== 12'hFF0) begin errors++; $display("FAIL restart_pix got %h exp FF0", {vid.red, vid.green, vid.blue}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vid.pix_ce = 1'b0;
        vid.hsync_in = 1'b1;
        vid.vsync_in = 1'b1;
        vid.col = '0;
        vid.row = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_bars();
        test_sync();
        test_buttons();
        test_checker();
`ifdef VGA_PATTERN_BORDER_EN
        test_border();
`endif
        test_box();
        test_solid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
